// File: rtl/ccheck_trace_fifo.sv
// CPU-to-checker trace FIFO: captures {pc, seq, operand lanes} per retired instruction,
// drops and counts records when full. Optional per-record timestamp via CCHECK_TIMESTAMP_EN.
module ccheck_trace_fifo #(
   parameter int DATA_W    = 32,
   parameter int NUM_LANES = 3,
   parameter int PC_W      = 32,
   parameter int DEPTH     = 16,
   parameter int SEQ_W     = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   input  logic [PC_W-1:0]             in_pc,
   input  logic [NUM_LANES*DATA_W-1:0] in_vals,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [PC_W-1:0]             out_pc,
   output logic [NUM_LANES*DATA_W-1:0] out_vals,
   output logic [SEQ_W-1:0]            out_seq,
   output logic [31:0]                 out_ts,
   output logic [$clog2(DEPTH):0]      count,
   output logic [SEQ_W-1:0]            drop_cnt,
   output logic                        overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int VW = NUM_LANES * DATA_W;

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [SEQ_W-1:0] seq_q, seq_d;
   logic [SEQ_W-1:0] drop_q, drop_d;
   logic             ovf_q, ovf_d;

   logic [PC_W-1:0]  pc_mem   [DEPTH];
   logic [VW-1:0]    vals_mem [DEPTH];
   logic [SEQ_W-1:0] seq_mem  [DEPTH];

   logic empty, full, pop, push, drop;

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));
   assign pop   = ~empty & out_ready;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign push  = in_valid & (~full | pop);
   assign drop  = in_valid & ~push;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      seq_d    = seq_q;
      drop_d   = drop_q;
      ovf_d    = ovf_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
      if (in_valid) seq_d = seq_q + SEQ_W'(1);
      if (drop) begin
         ovf_d = 1'b1;
         if (drop_q != '1) drop_d = drop_q + SEQ_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         seq_q    <= '0;
         drop_q   <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         seq_q    <= seq_d;
         drop_q   <= drop_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage needs no reset: head outputs are masked while empty.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         pc_mem[wr_ptr_q]   <= in_pc;
         vals_mem[wr_ptr_q] <= in_vals;
         seq_mem[wr_ptr_q]  <= seq_q;
      end
   end

`ifdef CCHECK_TIMESTAMP_EN
   logic [31:0] ts_q;
   logic [31:0] ts_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) ts_q <= '0;
      else     ts_q <= ts_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (push && !rst) ts_mem[wr_ptr_q] <= ts_q;
   end
`endif

   always_comb begin
      out_pc   = '0;
      out_vals = '0;
      out_seq  = '0;
      out_ts   = 32'h0;
      if (!empty) begin
         out_pc   = pc_mem[rd_ptr_q];
         out_vals = vals_mem[rd_ptr_q];
         out_seq  = seq_mem[rd_ptr_q];
`ifdef CCHECK_TIMESTAMP_EN
         out_ts   = ts_mem[rd_ptr_q];
`endif
      end
   end

   assign out_valid = ~empty;
   assign count     = count_q;
   assign drop_cnt  = drop_q;
   assign overflow  = ovf_q;

endmodule
